// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_segment_pkg;

    // Scan slot phase: all digits dark, then one digit driven.
    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // One displayable frame as captured from the handshake interface.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  point;
        logic [7:0]  mask;
    } frame_t;

    // Bit positions inside the active-high {dp,g,f,e,d,c,b,a} segment byte.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high a..g patterns for hex digits 0..F (b and d are lower case).
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Frame transfer channel into the scanner: payload plus valid/ready handshake.
interface seven_segment_scanner_if;

    logic [31:0] data;
    logic [7:0]  pointEnable;
    logic [7:0]  digitMask;
    logic        dataValid;
    logic        dataReady;

    modport master (
        output data,
        output pointEnable,
        output digitMask,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  data,
        input  pointEnable,
        input  digitMask,
        input  dataValid,
        output dataReady
    );

endinterface

// File: rtl/seven_segment_hex_decoder.sv
// Hex nibble to active-high a..g segment pattern (purely combinational).
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX_SEG[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scan controller for an 8-digit common-anode display.
// A frame is accepted into a pending buffer and promoted to the active
// buffer only when the digit index wraps, so a frame is never torn.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 16,
    parameter int DIGIT_COUNT     = 8
) (
    input  logic                   clock,
    input  logic                   resetN,
    seven_segment_scanner_if.slave bus,
    output logic [7:0]             segmentEnableN,
    output logic [7:0]             digitEnableN,
    output logic                   frameStart,
    output logic [2:0]             currentDigit
);

    localparam int              CNT_W      = $clog2(TICKS_PER_DIGIT);
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(DIGIT_COUNT - 1);

    scan_state_e      state;
    logic [CNT_W-1:0] tick;
    logic [2:0]       digit;

    frame_t active;
    frame_t pending;
    logic   pending_full;
    logic   pending_full_next;
    logic   data_ready;

    logic       slot_end;
    logic       frame_end;
    logic       accept;
    logic [3:0] nibble;
    logic [6:0] hex_segments;
    logic [7:0] drive_segments;

    assign slot_end      = (state == DRIVE) && (tick == LAST_TICK);
    assign frame_end     = slot_end && (digit == LAST_DIGIT);
    assign accept        = bus.dataValid && data_ready;
    assign bus.dataReady = data_ready;
    assign nibble        = active.data[{digit, 2'b00} +: 4];

    seven_segment_hex_decoder u_hex_decoder (
        .nibble   (nibble),
        .segments (hex_segments)
    );

    // Assemble the active-high segment byte for the digit being scanned.
    always_comb begin
        drive_segments                 = '0;
        drive_segments[SEG_G:SEG_A]    = hex_segments;
        drive_segments[SEG_DP]         = active.point[digit];
    end

    // Slot sequencer: blank guard, drive window, then advance to next digit.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!resetN) begin
            state <= BLANK;
            tick  <= '0;
            digit <= '0;
        end else begin
            case (state)
                BLANK: begin
                    tick <= tick + 1'b1;
                    if (tick == LAST_BLANK) begin
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (tick == LAST_TICK) begin
                        tick  <= '0;
                        state <= BLANK;
                        digit <= (digit == LAST_DIGIT) ? 3'd0 : digit + 3'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    tick  <= '0;
                end
            endcase
        end
    end

    // Next occupancy of the pending buffer; ready is registered from this so
    // it always equals the complement of the pending flag.
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (no latch).
        pending_full_next = pending_full;
        if (frame_end) begin
            pending_full_next = 1'b0;
        end
        if (accept) begin
            pending_full_next = 1'b1;
        end
    end

    // Handshake capture and frame-boundary promotion of pending to active.
    always_ff @(posedge clock) begin
        // NOTE: both buffers are ordinary flops, so clearing them on reset is cheap and intended.
        if (!resetN) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            data_ready   <= 1'b0;
        end else begin
            if (frame_end && pending_full) begin
                active <= pending;
            end
            if (accept) begin
                pending <= '{data: bus.data, point: bus.pointEnable, mask: bus.digitMask};
            end
            pending_full <= pending_full_next;
            data_ready   <= !pending_full_next;
        end
    end

    // Registered pin drivers, one cycle behind the sequencer state.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            segmentEnableN <= 8'hFF;
            digitEnableN   <= 8'hFF;
            frameStart     <= 1'b0;
            currentDigit   <= 3'd0;
        end else begin
            frameStart   <= (state == BLANK) && (tick == '0) && (digit == 3'd0);
            currentDigit <= digit;
            if (state == DRIVE) begin
                digitEnableN   <= active.mask[digit] ? ~(8'h01 << digit) : 8'hFF;
                segmentEnableN <= ~drive_segments;
            end else begin
                digitEnableN   <= 8'hFF;
                segmentEnableN <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with short scan timing.
// A frame-level model tracks pending/active frames; accepted frames are
// queued and popped at each frame boundary, and every pin is compared
// on every cycle against the pattern the model predicts.
module tb_seven_segment_scanner;

    localparam int T     = 8;
    localparam int B     = 2;
    localparam int D     = 8;
    localparam int FRAME = T * D;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  point;
        logic [7:0]  mask;
    } frame_t;

    logic       clock = 1'b0;
    logic       resetN;
    logic [7:0] segment_enable_n;
    logic [7:0] digit_enable_n;
    logic       frame_start;
    logic [2:0] current_digit;

    seven_segment_scanner_if bus ();

    seven_segment_scanner #(
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B),
        .DIGIT_COUNT     (D)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .bus            (bus),
        .segmentEnableN (segment_enable_n),
        .digitEnableN   (digit_enable_n),
        .frameStart     (frame_start),
        .currentDigit   (current_digit)
    );

    always #5 clock = ~clock;

    frame_t sb_q[$];
    frame_t active_m;
    int     s;
    bit     ready_m;
    int     checks;
    int     passes;
    int     fails;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (state index %0d)", tag, observed, expected, s);
        end
    endtask

    // One clock: predict the pins for this edge from the model, advance the
    // model, then compare all pins on the following falling edge.
    task automatic step(output bit accepted);
        frame_t     offered;
        bit         hs;
        logic [7:0] es;
        logic [7:0] ed;
        logic       ef;
        logic [2:0] ec;
        logic       er;
        int         d;
        int         c;
        offered = '{data: bus.data, point: bus.pointEnable, mask: bus.digitMask};
        hs      = (resetN === 1'b1) && (bus.dataValid === 1'b1) && ready_m;
        @(posedge clock);
        if (resetN !== 1'b1) begin
            sb_q.delete();
            active_m = '0;
            s        = 0;
            ready_m  = 1'b0;
            hs       = 1'b0;
            es = 8'hFF; ed = 8'hFF; ef = 1'b0; ec = 3'd0; er = 1'b0;
        end else begin
            d  = (s / T) % D;
            c  = s % T;
            ef = (s % FRAME == 0);
            ec = 3'(d);
            if (c < B) begin
                es = 8'hFF;
                ed = 8'hFF;
            end else begin
                ed = active_m.mask[d] ? ~(8'h01 << d) : 8'hFF;
                es = ~{active_m.point[d], hex7(active_m.data[4*d +: 4])};
            end
            if ((s % FRAME == FRAME - 1) && (sb_q.size() > 0)) begin
                active_m = sb_q.pop_front();
            end
            if (hs) begin
                sb_q.push_back(offered);
            end
            ready_m = (sb_q.size() == 0);
            er      = ready_m;
            s++;
        end
        accepted = hs;
        @(negedge clock);
        check("segmentEnableN", segment_enable_n, es);
        check("digitEnableN", digit_enable_n, ed);
        check("frameStart", {7'd0, frame_start}, {7'd0, ef});
        check("currentDigit", {5'd0, current_digit}, {5'd0, ec});
        check("dataReady", {7'd0, bus.dataReady}, {7'd0, er});
    endtask

    task automatic run(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    task automatic wait_to(input int phase);
        bit a;
        while (s % FRAME != phase) step(a);
    endtask

    task automatic send(input frame_t f, input int budget);
        bit a;
        bit done;
        done            = 1'b0;
        bus.data        = f.data;
        bus.pointEnable = f.point;
        bus.digitMask   = f.mask;
        bus.dataValid   = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            step(a);
            done = a;
        end
        bus.dataValid = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $error("FAIL send_timeout: observed not accepted expected accepted within %0d cycles", budget);
        end
    endtask

    initial begin
        checks          = 0;
        passes          = 0;
        fails           = 0;
        s               = 0;
        ready_m         = 1'b0;
        active_m        = '0;
        resetN          = 1'b0;
        bus.data        = '0;
        bus.pointEnable = '0;
        bus.digitMask   = '0;
        bus.dataValid   = 1'b0;

        // Reset held for three edges: dark display, not ready.
        run(3);
        resetN = 1'b1;

        // First released edge: frameStart pulse and ready rises.
        run(1);

        // Counting pattern, all digits enabled; shown in the next frame.
        send('{data: 32'h76543210, point: 8'h00, mask: 8'hFF}, 10);

        // Decimal point and single-digit mask; waits for pending to clear.
        send('{data: 32'h0000000F, point: 8'h01, mask: 8'h01}, 2 * FRAME);

        // Back-pressure: capture one edge before the boundary, then two more.
        wait_to(0);
        wait_to(FRAME - 2);
        send('{data: 32'hFEDCBA98, point: 8'h80, mask: 8'hFF}, 1);
        send('{data: 32'h13579BDF, point: 8'h55, mask: 8'hF0}, 4);
        send('{data: 32'h2468ACE0, point: 8'hFF, mask: 8'h0F}, 2 * FRAME);

        // Boundary collision: handshake on the wrap edge with pending empty.
        wait_to(0);
        wait_to(FRAME - 1);
        send('{data: 32'h89ABCDEF, point: 8'hAA, mask: 8'h5A}, 1);
        run(2 * FRAME);

        // Mid-scan reset during digit 5 drive with a frame still pending.
        send('{data: 32'h55555555, point: 8'hFF, mask: 8'hFF}, 2 * FRAME);
        wait_to(5 * T + 4);
        resetN = 1'b0;
        run(2);
        resetN = 1'b1;
        run(2 * FRAME + 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
